// File: rtl/cbs_credit_shaper_pkg.sv
// Shared types and saturating credit arithmetic for the credit-based shaper.
package cbs_pkg;

    localparam int CREDIT_WIDTH_DEF = 32;
    localparam int SLOPE_WIDTH_DEF  = 16;
    localparam int ACC_WIDTH        = CREDIT_WIDTH_DEF + 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } cbs_state_e;

    typedef enum logic [1:0] {
        CR_HOLD  = 2'd0,
        CR_CLEAR = 2'd1,
        CR_IDLE  = 2'd2,
        CR_BEAT  = 2'd3
    } credit_op_e;

    // Two guard bits keep the sum exact; the clamp then brings it back into range.
    function automatic logic signed [CREDIT_WIDTH_DEF-1:0] sat_add(
        input logic signed [CREDIT_WIDTH_DEF-1:0] acc,
        input logic signed [ACC_WIDTH-1:0]        delta,
        input logic signed [CREDIT_WIDTH_DEF-1:0] lo,
        input logic signed [CREDIT_WIDTH_DEF-1:0] hi
    );
        logic signed [ACC_WIDTH-1:0] sum;
        sum = ACC_WIDTH'(acc) + delta;
        if (sum > ACC_WIDTH'(hi)) return hi;
        if (sum < ACC_WIDTH'(lo)) return lo;
        return $signed(sum[CREDIT_WIDTH_DEF-1:0]);
    endfunction

endpackage

// File: rtl/cbs_credit_shaper_if.sv
// AXI4-Stream bundle used on both sides of the shaper.
interface cbs_credit_shaper_if #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int C_AXIS_TUSER_WIDTH = 2
);
    logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
    logic [C_AXIS_TKEEP_WIDTH-1:0] tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser;
    logic                          tlast;
    logic                          tvalid;
    logic                          tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/cbs_credit_shaper_credit_counter.sv
// Signed credit accumulator: hold, clear, add idle slope, or add idle minus send slope.
module cbs_credit_counter
    import cbs_pkg::*;
#(
    parameter int CREDIT_WIDTH = CREDIT_WIDTH_DEF,
    parameter int SLOPE_WIDTH  = SLOPE_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  credit_op_e                     op_i,
    input  logic        [SLOPE_WIDTH-1:0]  idle_slope_i,
    input  logic        [SLOPE_WIDTH-1:0]  send_slope_i,
    input  logic signed [CREDIT_WIDTH-1:0] hi_i,
    input  logic signed [CREDIT_WIDTH-1:0] lo_i,
    output logic signed [CREDIT_WIDTH-1:0] credit_o
);
    logic signed [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic signed [ACC_WIDTH-1:0]    idle_ext, send_ext, delta;

    assign idle_ext = $signed({{(ACC_WIDTH-SLOPE_WIDTH){1'b0}}, idle_slope_i});
    assign send_ext = $signed({{(ACC_WIDTH-SLOPE_WIDTH){1'b0}}, send_slope_i});
    assign delta    = (op_i == CR_BEAT) ? (idle_ext - send_ext) : idle_ext;

    always_comb begin
        credit_d = credit_q;
        case (op_i)
            CR_CLEAR:         credit_d = '0;
            CR_IDLE, CR_BEAT: credit_d = sat_add(credit_q, delta, lo_i, hi_i);
            default:          credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit_q <= '0;
        else        credit_q <= credit_d;
    end

    assign credit_o = credit_q;
endmodule

// File: rtl/cbs_credit_shaper.sv
// Credit-based shaper for one stream class: gates frame starts on negative credit,
// never cuts a frame that is already in flight.
module cbs_credit_shaper
    import cbs_pkg::*;
#(
    parameter int CREDIT_WIDTH = CREDIT_WIDTH_DEF,
    parameter int SLOPE_WIDTH  = SLOPE_WIDTH_DEF
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    cbs_credit_shaper_if.slave             s_axis,
    cbs_credit_shaper_if.master            m_axis,
    input  logic                           enable,
    input  logic        [SLOPE_WIDTH-1:0]  idle_slope,
    input  logic        [SLOPE_WIDTH-1:0]  send_slope,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    input  logic signed [CREDIT_WIDTH-1:0] lo_credit,
    output logic signed [CREDIT_WIDTH-1:0] credit,
    output logic                           gate_open,
    output logic                           frame_active
);
    cbs_state_e state_q;
    logic       en_q;
    logic       frame_active_q;
    logic       pass;
    logic       out_valid;
    logic       beat;
    credit_op_e op;

    // Once a frame has started, the gate stays open until its last beat.
    assign pass      = !en_q || (state_q == ST_SEND) || !credit[CREDIT_WIDTH-1];
    assign out_valid = s_axis.tvalid & pass & aresetn;
    assign beat      = out_valid & m_axis.tready;

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tkeep  = s_axis.tkeep;
    assign m_axis.tuser  = s_axis.tuser;
    assign m_axis.tlast  = s_axis.tlast;
    assign s_axis.tready = m_axis.tready & pass & aresetn;

    assign gate_open    = pass;
    assign frame_active = frame_active_q;

    always_comb begin
        op = CR_HOLD;
        if (!en_q)
            op = CR_CLEAR;
        else if (beat)
            op = CR_BEAT;
        else if (s_axis.tvalid || credit[CREDIT_WIDTH-1] || (state_q == ST_SEND))
            op = CR_IDLE;
        else if (credit != '0)
            op = CR_CLEAR;
    end

    // Enable is only sampled between frames so a frame is shaped consistently end to end.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            en_q           <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_q <= enable;
                    if (beat && !s_axis.tlast) begin
                        state_q        <= ST_SEND;
                        frame_active_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (beat && s_axis.tlast) begin
                        state_q        <= ST_IDLE;
                        frame_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    frame_active_q <= 1'b0;
                end
            endcase
        end
    end

    cbs_credit_counter #(
        .CREDIT_WIDTH(CREDIT_WIDTH),
        .SLOPE_WIDTH (SLOPE_WIDTH)
    ) u_credit (
        .clk         (aclk),
        .rst_n       (aresetn),
        .op_i        (op),
        .idle_slope_i(idle_slope),
        .send_slope_i(send_slope),
        .hi_i        (hi_credit),
        .lo_i        (lo_credit),
        .credit_o    (credit)
    );
endmodule

// File: doc/cbs_credit_shaper.md
# cbs_credit_shaper

Credit-based shaper (IEEE 802.1Qav style) for one AXI4-Stream traffic class. Sits in the CBS path between the class queue and the egress transmission selector. It keeps a signed credit counter fed by per-cycle idle/send slopes. It gates frame starts while credit is negative and never interrupts a frame in progress.

## Interface
- C_AXIS_TDATA_WIDTH, 64, stream data width
- C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8, keep width
- C_AXIS_TUSER_WIDTH, 2, sideband width, passed through untouched
- CREDIT_WIDTH, 32, signed credit width
- SLOPE_WIDTH, 16, unsigned slope width
- aclk  in  1  clock; one clock domain
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata/tkeep/tuser/tlast/tvalid  in  per params  upstream stream
- s_axis_tready  out  1  upstream ready
- m_axis_tdata/tkeep/tuser/tlast/tvalid  out  per params  downstream stream
- m_axis_tready  in  1  downstream ready
- enable  in  1  shaping enable; 0 = transparent
- idle_slope  in  SLOPE_WIDTH  credit gained per non-transfer cycle
- send_slope  in  SLOPE_WIDTH  credit lost per transferred beat
- hi_credit  in  CREDIT_WIDTH  signed upper clamp, ≥0
- lo_credit  in  CREDIT_WIDTH  signed lower clamp, ≤0
- credit  out  CREDIT_WIDTH  current credit, registered
- gate_open  out  1  frame start currently permitted
- frame_active  out  1  state == SEND

## Operation
- States: IDLE (between frames), SEND (frame in progress).
- IDLE→SEND on a beat transferred with tlast=0. Any state→IDLE on a beat with tlast=1. A single-beat frame stays in IDLE.
- en_q: registered copy of enable. Loaded only in IDLE, so enable changes take effect at the next frame boundary.
- pass = !en_q || state==SEND || credit ≥ 0.
- m_axis_tvalid = s_axis_tvalid & pass. s_axis_tready = m_axis_tready & pass. Data, keep, user and last pass through combinationally.
- beat = m_axis_tvalid & m_axis_tready.
- Credit update per cycle, evaluated in priority order:
  - en_q=0: credit ← 0.
  - beat: credit ← credit + idle_slope − send_slope.
  - no beat, and (s_axis_tvalid or credit<0 or state==SEND): credit ← credit + idle_slope.
  - no beat, queue empty (s_axis_tvalid=0), IDLE, credit>0: credit ← 0.
  - otherwise: hold.
- Arithmetic: slopes zero-extended to CREDIT_WIDTH+2 bits signed. The sum is computed at full width, then saturated to [lo_credit, hi_credit]. Never wraps.
- gate_open = pass.
- hi_credit/lo_credit/slopes are live inputs, sampled every cycle. Software changes them only while enable=0.

## Timing
- Zero-latency datapath. Gate is combinational from registered credit/state/en_q.
- Credit reflects a beat one cycle later. A blocked frame starts in the cycle after credit becomes ≥0.
- Mid-frame: the gate never closes, regardless of credit. tready drops only when m_axis_tready drops.
- Reset asserted (async) or out of reset: credit=0, state=IDLE, en_q=0, frame_active=0. While aresetn=0, m_axis_tvalid=0 and s_axis_tready=0 are forced.
- Reset mid-frame: the frame is truncated downstream. Upstream is responsible for flushing.
- Simultaneous tlast beat and enable change: en_q is loaded from enable in the first IDLE cycle after tlast.

## Structure
- Package cbs_pkg:
  - state enum (IDLE/SEND)
  - CREDIT_WIDTH/SLOPE_WIDTH defaults
  - saturating signed add function
- Sub-module cbs_credit_counter: signed accumulator with add/sub/clear/hold controls and clamp inputs. Owns the credit register.
- Top level: FSM, en_q, gate logic.

## Test plan
Common settings unless stated: idle_slope=2, send_slope=6, hi=100, lo=−100, enable=1, m_axis_tready=1.
- Frame throttling: 4-beat frame from reset → passes with no stall; credit=−16 after the last beat. A queued 2nd frame is held 8 cycles, starts in cycle 9, credit passes through 0.
- No mid-frame cut: 10-beat frame → 10 consecutive beats with s_axis_tready high throughout; credit=−40 at end.
- Lower clamp: lo=−20, 10-beat frame → credit saturates at −20, never below.
- Upper clamp and empty reset: tvalid held with m_axis_tready=0 for 60 cycles → credit=100 (clamped). Then a 1-beat frame → credit=96. Queue then empty → credit=0 the next cycle.
- Enable at boundary: enable=0 asserted mid-frame → shaping continues to tlast. Next frame passes while credit is −24; credit reads 0 afterwards.
- Async reset mid-frame: aresetn low at beat 3 → m_axis_tvalid=0, credit=0, frame_active=0 in the same cycle. After release, the next frame passes immediately.
